multdiv: RTL and testbench
==========================

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port data_operandA, input, WIDTH bits: multiplicand or dividend, two's complement.
REQ-005 SHALL have port data_operandB, input, WIDTH bits: multiplier or divisor, two's complement.
REQ-006 SHALL have port ctrl_MULT, input, 1 bit: one-cycle start pulse for a signed multiply.
REQ-007 SHALL have port ctrl_DIV, input, 1 bit: one-cycle start pulse for a signed divide.
REQ-008 SHALL have port data_result, output, WIDTH bits: low WIDTH bits of the product, or the quotient.
REQ-009 SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-010 SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 SHALL sample operands only in the cycle a start pulse is high (cycle 0); operand changes afterwards SHALL be ignored.
REQ-012 SHALL implement states IDLE, MUL_RUN, DIV_RUN, DONE: IDLE->MUL_RUN on ctrl_MULT; IDLE->DIV_RUN on ctrl_DIV; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 SHALL run one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle, on operand magnitudes, with sign fix-up at completion.
REQ-014 SHALL assert data_resultRDY for exactly one cycle, in cycle WIDTH+1 (cycle 33 at default) after the start pulse.
REQ-015 SHALL hold data_result and data_exception stable from the RDY cycle until the next start pulse or reset.
REQ-016 Multiply SHALL output the low WIDTH bits of the signed 2*WIDTH product and SHALL set exception iff the product does not fit in WIDTH signed bits.
REQ-017 Divide SHALL output the quotient truncated toward zero; the remainder is discarded.
REQ-018 Divisor zero SHALL give result 0 and exception 1, with the standard latency.
REQ-019 Dividend -2^(WIDTH-1) with divisor -1 SHALL give result -2^(WIDTH-1) and exception 1.
REQ-020 ctrl_MULT and ctrl_DIV high together SHALL be treated as multiply.
REQ-021 A start pulse in any state other than IDLE SHALL abort the current operation without RDY, latch the new operands and restart the count from cycle 0.
REQ-022 A start pulse in the DONE cycle SHALL be accepted; the RDY for the previous operation SHALL still be issued in that cycle.

Reset
REQ-023 Reset SHALL force state IDLE, data_result 0, data_exception 0, data_resultRDY 0 and the iteration counter 0 on the next edge.
REQ-024 Reset SHALL take priority over a start pulse in the same cycle; reset mid-operation SHALL cancel it with no RDY pulse.

Configuration
REQ-025 With MULTDIV_EARLY_ZERO_EN defined, multiply with either operand 0, divide with dividend 0, or divide with divisor 0 SHALL go straight to DONE, with RDY in cycle 1 and the same result and exception values.
REQ-026 Without MULTDIV_EARLY_ZERO_EN, every operation SHALL take exactly WIDTH+1 cycles.

Structure
REQ-027 Package multdiv_pkg SHALL hold the state enum, default WIDTH and the iteration-count constant.
REQ-028 The WIDTH+1-bit add/subtract datapath SHALL be a sub-module named multdiv_addsub, shared by both operations.

Verification
REQ-029 MULT 7 x -6 -> result 0xFFFFFFD6, exception 0, RDY high only in cycle 33.
REQ-030 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; MULT 0x80000000 x 1 -> 0x80000000, exception 0.
REQ-031 DIV -43 / 5 -> 0xFFFFFFF8; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-032 DIV 100 / 0 -> result 0, exception 1, RDY in cycle 33 without the macro and in cycle 1 with it.
REQ-033 MULT 3 x 4, then DIV 20 / 3 at cycle 10 -> no RDY at cycle 33 of the first op; single RDY 33 cycles after the DIV pulse with result 6.
REQ-034 Reset at cycle 15 of MULT 5 x 5 -> outputs 0, no RDY; a new MULT 5 x 5 afterwards -> result 25.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative signed multiply/divide unit
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // One iteration per result bit.
  function automatic int iter_count(input int width);
    return width;
  endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - WIDTH+1-bit adder/subtractor shared by the multiply and divide iterations
module multdiv_addsub
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);

  assign y = a + (b ^ {(WIDTH + 1){sub}}) + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed shift-add multiply / restoring divide, WIDTH+1 cycle latency
// MULTDIV_EARLY_ZERO_EN: zero operands finish in one cycle instead of running the full count.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int ITERS = iter_count(WIDTH);
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               neg_q, neg_d, zdiv_q, zdiv_d, exc_q, exc_d;

  logic               start, start_mul, last_iter, early_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, quot_mag, quot_s;
  logic [WIDTH:0]     as_a, as_b, as_y;
  logic               as_sub;
  logic [2*WIDTH-1:0] prod_mag, prod_s;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_mul = ctrl_MULT;
  assign last_iter = (cnt_q == LAST_CNT);
  assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_ZERO_EN
  assign early_zero = (data_operandA == '0) || (data_operandB == '0);
`else
  assign early_zero = 1'b0;
`endif

  // hi holds the partial product (multiply) or partial remainder (divide); lo shifts out multiplier / in quotient.
  always_comb begin
    as_sub = (state_q == DIV_RUN);
    as_a   = {1'b0, hi_q};
    as_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
    if (state_q == DIV_RUN) begin
      as_a = {hi_q, lo_q[WIDTH-1]};
      as_b = {1'b0, opnd_q};
    end
  end

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  assign prod_mag = {as_y, lo_q[WIDTH-1:1]};
  assign prod_s   = neg_q ? -prod_mag : prod_mag;
  assign quot_mag = {lo_q[WIDTH-2:0], ~as_y[WIDTH]};
  assign quot_s   = neg_q ? -quot_mag : quot_mag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zdiv_q   <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zdiv_q   <= zdiv_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = early_zero ? DONE : (start_mul ? MUL_RUN : DIV_RUN);
    end else begin
      case (state_q)
        MUL_RUN, DIV_RUN: if (last_iter) state_d = DONE;
        DONE:             state_d = IDLE;
        default:          state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    zdiv_d   = zdiv_q;
    exc_d    = exc_q;
    if (start) begin
      cnt_d  = '0;
      neg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      zdiv_d = (data_operandB == '0);
      hi_d   = '0;
      opnd_d = start_mul ? abs_a : abs_b;
      lo_d   = start_mul ? abs_b : abs_a;
      if (early_zero) begin
        result_d = '0;
        exc_d    = !start_mul && (data_operandB == '0);
      end
    end else if (state_q == MUL_RUN) begin
      hi_d  = as_y[WIDTH:1];
      lo_d  = {as_y[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        result_d = prod_s[WIDTH-1:0];
        exc_d    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
      end
    end else if (state_q == DIV_RUN) begin
      hi_d  = as_y[WIDTH] ? as_a[WIDTH-1:0] : as_y[WIDTH-1:0];
      lo_d  = quot_mag;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        // A positive quotient magnitude of 2^(WIDTH-1) only arises from MIN / -1.
        result_d = zdiv_q ? '0 : quot_s;
        exc_d    = zdiv_q || (quot_mag[WIDTH-1] && !neg_q);
      end
    end
  end

  always_comb begin
    data_resultRDY = (state_q == DONE);
    data_result    = result_q;
    data_exception = exc_q;
  end

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - self-checking bench for multdiv against a plain-arithmetic reference model
module tb_multdiv;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_operandA, data_operandB;
  logic         ctrl_MULT, ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY;

  int n_checks = 0;
  int n_errors = 0;

  logic         cur_mul;
  logic [W-1:0] cur_a, cur_b, exp_res;
  logic         exp_exc;

  typedef struct {
    bit           m;
    bit           d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    bit           e;
  } dir_t;

  dir_t dirs[10];

  multdiv #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic exc);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mul) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      res = '0;
      exc = 1'b1;
    end else begin
      p   = sa / sb;
      res = p[31:0];
      exc = (p > 64'sd2147483647);
    end
  endfunction

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTDIV_EARLY_ZERO_EN
    if (a == 0 || b == 0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 200)) - 32'd100;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic launch(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    cur_mul = m;
    cur_a = a;
    cur_b = b;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic finish(input string tag);
    int cyc;
    cyc = 1;
    while (!data_resultRDY && cyc < 200) begin
      tick();
      cyc++;
    end
    model(cur_mul, cur_a, cur_b, exp_res, exp_exc);
    check_eq({tag, "_rdy_cycle"}, cyc, latency(cur_a, cur_b));
    check_eq({tag, "_result"}, data_result, exp_res);
    check_eq({tag, "_exception"}, data_exception, exp_exc);
  endtask

  task automatic settle(input string tag);
    tick();
    check_eq({tag, "_rdy_single"}, data_resultRDY, 1'b0);
    repeat (3) tick();
    check_eq({tag, "_hold_result"}, data_result, exp_res);
    check_eq({tag, "_hold_exception"}, data_exception, exp_exc);
  endtask

  task automatic count_rdy(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (data_resultRDY) seen++;
      tick();
    end
  endtask

  initial begin
    int seen;
    bit chain;
    string tag;

    dirs[0] = '{1, 0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 0};
    dirs[1] = '{1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1};
    dirs[2] = '{1, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 0};
    dirs[3] = '{0, 1, 32'hFFFF_FFD5, 32'd5,         32'hFFFF_FFF8, 0};
    dirs[4] = '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    dirs[5] = '{0, 1, 32'd100,       32'd0,         32'h0000_0000, 1};
    dirs[6] = '{1, 1, 32'hFFFF_FFF7, 32'd7,         32'hFFFF_FFC1, 0};
    dirs[7] = '{0, 1, 32'h8000_0000, 32'd1,         32'h8000_0000, 0};
    dirs[8] = '{1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    dirs[9] = '{0, 1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_result", data_result, '0);
    check_eq("reset_exception", data_exception, 1'b0);
    check_eq("reset_rdy", data_resultRDY, 1'b0);

    foreach (dirs[i]) begin
      tag = $sformatf("dir%0d", i);
      launch(dirs[i].m, dirs[i].d, dirs[i].a, dirs[i].b);
      finish(tag);
      check_eq({tag, "_const_result"}, data_result, dirs[i].r);
      check_eq({tag, "_const_exception"}, data_exception, dirs[i].e);
      settle(tag);
    end

    // Restart by a DIV pulse in cycle 10 of a running multiply.
    launch(1, 0, 32'd3, 32'd4);
    count_rdy(9, seen);
    check_eq("abort_no_rdy", seen, 0);
    launch(0, 1, 32'd20, 32'd3);
    finish("abort_div");
    check_eq("abort_div_const", data_result, 32'd6);
    settle("abort_div");

    // Reset in cycle 15 of a multiply cancels it.
    launch(1, 0, 32'd5, 32'd5);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midreset_result", data_result, '0);
    check_eq("midreset_exception", data_exception, 1'b0);
    check_eq("midreset_rdy", data_resultRDY, 1'b0);
    count_rdy(40, seen);
    check_eq("midreset_no_rdy", seen, 0);
    launch(1, 0, 32'd5, 32'd5);
    finish("after_reset");
    check_eq("after_reset_const", data_result, 32'd25);
    settle("after_reset");

    // Reset wins over a simultaneous start pulse.
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd3;
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    count_rdy(40, seen);
    check_eq("reset_prio_no_rdy", seen, 0);
    check_eq("reset_prio_result", data_result, '0);

    chain = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int op;
      tag = $sformatf("rnd%0d", n);
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(1, 31);
        launch(1, 0, pick() | 32'd1, pick() | 32'd1);
        count_rdy(k - 1, seen);
        check_eq({tag, "_abort_no_rdy"}, seen, 0);
      end
      op = $urandom_range(0, 2);
      launch(op != 1, op != 0, pick(), pick());
      finish(tag);
      chain = ($urandom_range(0, 2) == 0) && (n != 39);
      if (!chain) settle(tag);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
